// File: rtl/prog_clk_div_if.sv
// Control/status bundle for prog_clk_div: enable, ratio and duty select in; divided clock, tick and active ratio out.
// Latency: none, this is wiring only.
// Backpressure: none. The divider is free-running and every signal is level-based.
// Ports: i_clk_en, i_div_ratio, i_odd_50 (driver -> divider); o_div_clk, o_div_tick, o_ratio_act (divider -> consumer).
interface prog_clk_div_if #(
  parameter int WIDTH = 8
);
  logic             i_clk_en;
  logic [WIDTH-1:0] i_div_ratio;
  logic             i_odd_50;
  logic             o_div_clk;
  logic             o_div_tick;
  logic [WIDTH-1:0] o_ratio_act;

  // master drives the controls and observes the divider
  modport master (
    output i_clk_en, i_div_ratio, i_odd_50,
    input  o_div_clk, o_div_tick, o_ratio_act
  );

  // slave is the divider itself
  modport slave (
    input  i_clk_en, i_div_ratio, i_odd_50,
    output o_div_clk, o_div_tick, o_ratio_act
  );
endinterface

// File: rtl/prog_clk_div.sv
// Programmable integer clock divider: divides i_ref_clk by N (2..2^WIDTH-1), with optional exact 50% duty for odd N.
// Latency: a divided period starts on the posedge after the ratio is sampled; ratio changes apply at the next period boundary.
// Backpressure: none. Bypass (en=0 or ratio<2) passes i_ref_clk straight through.
// Ports: i_ref_clk, i_rst_n (async, active-low); bus (slave modport) carries the enable, ratio, odd-50 select,
//        the divided clock, the period tick and the active ratio.
module prog_clk_div #(
  parameter int WIDTH = 8
) (
  input  logic         i_ref_clk,
  input  logic         i_rst_n,
  prog_clk_div_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);
  localparam logic [WIDTH:0]   EXT_ONE = (WIDTH + 1)'(1);

  typedef enum logic {
    ST_BYPASS = 1'b0,
    ST_DIVIDE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_ratio, ratio_d;
  logic             r_odd50, odd_d;
  logic             pos_clk, pos_d;
  logic             neg_clk;
  logic             tick_q, tick_d;
  logic             upd;
  logic             period_end;
  logic [WIDTH:0]   ratio_ext;
  logic [WIDTH:0]   high_cnt;
  logic             bypass_now;
  logic             use_neg;

  // only meaningful in ST_DIVIDE, where r_ratio >= 2
  assign period_end = (cnt_q == (r_ratio - ONE));

  // Next-state logic. The ratio and duty select are re-sampled on every edge
  // while bypassed, and only at the last cycle of a period while dividing, so
  // a ratio write mid-period never truncates the running period.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    ratio_d   = r_ratio;
    odd_d     = r_odd50;
    upd       = 1'b0;
    ratio_ext = '0;
    high_cnt  = '0;
    pos_d     = 1'b0;
    tick_d    = 1'b0;

    case (state_q)
      ST_BYPASS: upd = 1'b1;
      ST_DIVIDE: upd = !bus.i_clk_en || period_end;
      default:   upd = 1'b1;
    endcase

    if (upd) begin
      ratio_d = bus.i_div_ratio;
      odd_d   = bus.i_odd_50;
    end

    if (bus.i_clk_en && (ratio_d >= TWO)) begin
      state_d = ST_DIVIDE;
      // a fresh period (entry or boundary) restarts at 0
      cnt_d   = upd ? '0 : (cnt_q + ONE);
    end else begin
      state_d = ST_BYPASS;
      cnt_d   = '0;
    end

    // High count in ref cycles, computed one bit wider so N = 2^WIDTH-1
    // cannot overflow on (N+1)/2. Odd N with odd-50 keeps (N-1)/2 on the
    // posedge flop; the negedge flop supplies the extra half cycle.
    ratio_ext = {1'b0, ratio_d};
    if (ratio_d[0] && odd_d) begin
      high_cnt = ratio_ext >> 1;
    end else begin
      high_cnt = (ratio_ext + EXT_ONE) >> 1;
    end

    if (state_d == ST_DIVIDE) begin
      pos_d  = ({1'b0, cnt_d} < high_cnt);
      tick_d = (cnt_d == '0);
    end
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_BYPASS;
      cnt_q   <= '0;
      r_ratio <= '0;
      r_odd50 <= 1'b0;
      pos_clk <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_ratio <= ratio_d;
      r_odd50 <= odd_d;
      pos_clk <= pos_d;
      tick_q  <= tick_d;
    end
  end

  // Half-cycle delayed copy of pos_clk; OR-ing it in stretches the high
  // phase by half a ref period for odd ratios.
  always_ff @(negedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      neg_clk <= 1'b0;
    end else begin
      neg_clk <= pos_clk;
    end
  end

  // Dropping the enable bypasses immediately, without waiting for an edge.
  assign bypass_now = !bus.i_clk_en || (state_q == ST_BYPASS);
  assign use_neg    = r_ratio[0] && r_odd50;

  assign bus.o_div_clk   = bypass_now ? i_ref_clk
                         : (use_neg ? (pos_clk | neg_clk) : pos_clk);
  assign bus.o_div_tick  = tick_q && !bypass_now;
  assign bus.o_ratio_act = r_ratio;

endmodule
